// File: rtl/button_input_conditioner.sv
// Conditions raw board push-buttons for the counter core.
// Per button: two-flop synchroniser, debounce filter, stable level output and
// one-cycle press, release and auto-repeat pulses.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   buttons       raw button pins, asynchronous to clk
//   pressed       debounced level, active-high regardless of ACTIVE_LOW
//   press_pulse   one-cycle pulse on the edge pressed rises
//   release_pulse one-cycle pulse on the edge pressed falls
//   repeat_pulse  one-cycle auto-repeat pulse while held
module button_input_conditioner #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned ACTIVE_LOW      = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_DELAY    = 64,
    parameter int unsigned REPEAT_PERIOD   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] buttons,
    output logic [WIDTH-1:0] pressed,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse,
    output logic [WIDTH-1:0] repeat_pulse
);

    // Pin level of a released button; also the synchroniser reset value so a
    // button held through reset is seen as a fresh press afterwards.
    localparam logic [WIDTH-1:0] IDLE_LEVEL = (ACTIVE_LOW != 0) ? '1 : '0;

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    localparam int unsigned RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                    : REPEAT_PERIOD;
    localparam int unsigned RP_W = (RP_MAX > 1) ? $clog2(RP_MAX) : 1;
    localparam logic [RP_W-1:0] DELAY_LAST  = RP_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [RP_W-1:0] PERIOD_LAST = RP_W'(REPEAT_PERIOD - 1);
    localparam logic REPEAT_EN = (REPEAT_DELAY != 0);

    typedef enum logic [1:0] {StIdle, StDelay, StRepeat} rep_state_e;

    logic [WIDTH-1:0] sync1_q, sync2_q, raw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= IDLE_LEVEL;
            sync2_q <= IDLE_LEVEL;
        end else begin
            sync1_q <= buttons;
            sync2_q <= sync1_q;
        end
    end

    // Active-high view of the synchronised pins.
    assign raw = sync2_q ^ IDLE_LEVEL;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [DB_W-1:0] db_cnt_q, db_cnt_d;
        logic            level_q, level_d;
        logic            rise, fall;
        rep_state_e      st_q, st_d;
        logic [RP_W-1:0] rp_cnt_q, rp_cnt_d;
        logic            rep_d;
        logic            press_q, release_q, rep_q;

        // Debounce: any cycle of agreement restarts the count.
        always_comb begin
            db_cnt_d = db_cnt_q;
            level_d  = level_q;
            if (raw[i] == level_q) begin
                db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
                level_d  = raw[i];
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
            rise = level_d & ~level_q;
            fall = ~level_d & level_q;
        end

        // Repeat FSM; release wins over a coincident terminal count.
        always_comb begin
            st_d     = st_q;
            rp_cnt_d = rp_cnt_q;
            rep_d    = 1'b0;
            if (fall) begin
                st_d     = StIdle;
                rp_cnt_d = '0;
            end else begin
                case (st_q)
                    StIdle: begin
                        if (rise && REPEAT_EN) begin
                            st_d     = StDelay;
                            rp_cnt_d = '0;
                        end
                    end
                    StDelay: begin
                        if (rp_cnt_q == DELAY_LAST) begin
                            rep_d    = 1'b1;
                            st_d     = StRepeat;
                            rp_cnt_d = '0;
                        end else begin
                            rp_cnt_d = rp_cnt_q + 1'b1;
                        end
                    end
                    StRepeat: begin
                        if (rp_cnt_q == PERIOD_LAST) begin
                            rep_d    = 1'b1;
                            rp_cnt_d = '0;
                        end else begin
                            rp_cnt_d = rp_cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        st_d     = StIdle;
                        rp_cnt_d = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                db_cnt_q  <= '0;
                level_q   <= 1'b0;
                st_q      <= StIdle;
                rp_cnt_q  <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                rep_q     <= 1'b0;
            end else begin
                db_cnt_q  <= db_cnt_d;
                level_q   <= level_d;
                st_q      <= st_d;
                rp_cnt_q  <= rp_cnt_d;
                press_q   <= rise;
                release_q <= fall;
                rep_q     <= rep_d;
            end
        end

        assign pressed[i]       = level_q;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = release_q;
        assign repeat_pulse[i]  = rep_q;
    end

endmodule

// File: tb/tb_button_input_conditioner.sv
module tb_button_input_conditioner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] buttons = 4'hF;
    logic [3:0] pressed, press_pulse, release_pulse, repeat_pulse;

    int n_cmp = 0;
    int n_bad = 0;

    button_input_conditioner #(
        .WIDTH          (4),
        .ACTIVE_LOW     (1),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (8),
        .REPEAT_PERIOD  (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .buttons      (buttons),
        .pressed      (pressed),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .repeat_pulse (repeat_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] e_pr, input logic [3:0] e_pp,
                              input logic [3:0] e_rl, input logic [3:0] e_rp);
        logic [15:0] got;
        logic [15:0] req;
        got = {pressed, press_pulse, release_pulse, repeat_pulse};
        req = {e_pr, e_pp, e_rl, e_rp};
        n_cmp++;
        assert (got === req) else begin
            n_bad++;
            $error("FAIL %s: observed pressed/press/release/repeat=%h required %h", tag, got, req);
        end
    endtask

    task automatic step(input string tag, input logic [3:0] e_pr, input logic [3:0] e_pp,
                        input logic [3:0] e_rl, input logic [3:0] e_rp);
        tick();
        expect_out(tag, e_pr, e_pp, e_rl, e_rp);
    endtask

    initial begin
        // 1. Reset with all buttons pressed-inactive pins, then idle
        rst = 1'b1;
        buttons = 4'hF;
        tick();
        tick();
        expect_out("reset_hold", 4'h0, 4'h0, 4'h0, 4'h0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) step("reset_idle", 4'h0, 4'h0, 4'h0, 4'h0);

        // 2. Clean press of bit 0, released before the first repeat
        buttons = 4'hE;
        for (int i = 0; i < 5; i++) step("press_wait", 4'h0, 4'h0, 4'h0, 4'h0);
        step("press_edge5", 4'h1, 4'h1, 4'h0, 4'h0);
        step("press_edge6", 4'h1, 4'h0, 4'h0, 4'h0);
        buttons = 4'hF;
        for (int i = 0; i < 5; i++) step("press_hold", 4'h1, 4'h0, 4'h0, 4'h0);
        step("release_edge", 4'h0, 4'h0, 4'h1, 4'h0);
        step("release_after", 4'h0, 4'h0, 4'h0, 4'h0);

        // 3. Bounce: 3 low / 1 high, five times, then hold low
        for (int r = 0; r < 5; r++) begin
            buttons = 4'hE;
            for (int i = 0; i < 3; i++) step("bounce_low", 4'h0, 4'h0, 4'h0, 4'h0);
            buttons = 4'hF;
            step("bounce_high", 4'h0, 4'h0, 4'h0, 4'h0);
        end
        buttons = 4'hE;
        for (int i = 0; i < 5; i++) step("bounce_wait", 4'h0, 4'h0, 4'h0, 4'h0);
        step("bounce_settle", 4'h1, 4'h1, 4'h0, 4'h0);
        buttons = 4'hF;
        for (int i = 0; i < 5; i++) step("bounce_hold", 4'h1, 4'h0, 4'h0, 4'h0);
        step("bounce_release", 4'h0, 4'h0, 4'h1, 4'h0);

        // 4. Auto-repeat on bit 1; release lands on a repeat terminal count
        buttons = 4'hD;
        for (int i = 0; i < 5; i++) step("rep_wait", 4'h0, 4'h0, 4'h0, 4'h0);
        step("rep_press", 4'h2, 4'h2, 4'h0, 4'h0);
        for (int k = 1; k <= 25; k++) begin
            if (k == 15) buttons = 4'hF;
            step("rep_seq", (k < 20) ? 4'h2 : 4'h0, 4'h0, (k == 20) ? 4'h2 : 4'h0,
                 (k == 8 || k == 11 || k == 14 || k == 17) ? 4'h2 : 4'h0);
        end

        // 5. Simultaneous press; bit 2 released on bit 3's repeat edge
        buttons = 4'h0;
        for (int i = 0; i < 5; i++) step("all_wait", 4'h0, 4'h0, 4'h0, 4'h0);
        step("all_press", 4'hF, 4'hF, 4'h0, 4'h0);
        buttons = 4'h3;
        for (int k = 1; k <= 19; k++) begin
            logic [3:0] e_pr, e_rl, e_rp;
            if (k == 6) buttons = 4'h7;
            if (k == 13) buttons = 4'hF;
            e_pr = (k < 6) ? 4'hF : (k < 11) ? 4'hC : (k < 18) ? 4'h8 : 4'h0;
            e_rl = (k == 6) ? 4'h3 : (k == 11) ? 4'h4 : (k == 18) ? 4'h8 : 4'h0;
            e_rp = (k == 8) ? 4'hC : (k == 11 || k == 14 || k == 17) ? 4'h8 : 4'h0;
            step("simul_seq", e_pr, 4'h0, e_rl, e_rp);
        end

        // 6. Reset while bit 0 is repeating, then re-detect the held press
        buttons = 4'hE;
        for (int i = 0; i < 5; i++) step("mid_wait", 4'h0, 4'h0, 4'h0, 4'h0);
        step("mid_press", 4'h1, 4'h1, 4'h0, 4'h0);
        for (int k = 1; k <= 9; k++)
            step("mid_seq", 4'h1, 4'h0, 4'h0, (k == 8) ? 4'h1 : 4'h0);
        #2;
        rst = 1'b1;
        #1;
        expect_out("rst_async", 4'h0, 4'h0, 4'h0, 4'h0);
        step("rst_held", 4'h0, 4'h0, 4'h0, 4'h0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step("repress_wait", 4'h0, 4'h0, 4'h0, 4'h0);
        step("repress", 4'h1, 4'h1, 4'h0, 4'h0);
        for (int k = 1; k <= 8; k++)
            step("repress_rep", 4'h1, 4'h0, 4'h0, (k == 8) ? 4'h1 : 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/button_input_conditioner.md
Name: button_input_conditioner

Overview:
- Input-side counterpart to the counter/LED output path: conditions raw board push-buttons before they reach the counter logic.
- Per button: synchronises the asynchronous pin, debounces it, and produces a stable level plus one-cycle press, release and auto-repeat pulses.
- Sits between the board button pins and the counter core, which consumes the pulses as increment/decrement/load commands.

Parameters:
- WIDTH, 4, number of independent buttons.
- ACTIVE_LOW, 1, 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed.
- DEBOUNCE_CYCLES, 16, consecutive cycles the synchronised input must differ from the stable level before the stable level changes (must be ≥1).
- REPEAT_DELAY, 64, cycles from PressPulse to the first RepeatPulse; 0 disables auto-repeat.
- REPEAT_PERIOD, 16, cycles between subsequent RepeatPulses (must be ≥1).

Ports:
- Clock  input  1  system clock.
- Reset  input  1  asynchronous, active-high reset.
- Buttons  input  WIDTH  raw button pins, asynchronous to Clock.
- Pressed  output  WIDTH  debounced level, active-high regardless of ACTIVE_LOW.
- PressPulse  output  WIDTH  one-cycle pulse when Pressed rises.
- ReleasePulse  output  WIDTH  one-cycle pulse when Pressed falls.
- RepeatPulse  output  WIDTH  one-cycle auto-repeat pulse while held.

Behaviour:
- Reset (async, active-high):
  - All outputs 0.
  - Debounce and repeat counters 0; every repeat FSM in IDLE.
  - Both synchroniser stages load the inactive pin level (1 if ACTIVE_LOW, else 0), so a button held through reset produces no spurious release.
- Synchroniser:
  - Two flops per bit.
  - raw = sync2 XOR ACTIVE_LOW, giving an active-high view.
- Debounce, per bit, counter width ceil(log2(DEBOUNCE_CYCLES)) with minimum 1:
  - raw == Pressed: counter cleared.
  - raw != Pressed and counter == DEBOUNCE_CYCLES-1: Pressed <= raw, counter cleared.
  - Otherwise the counter increments.
  - Any single-cycle agreement restarts the count, so glitches shorter than DEBOUNCE_CYCLES cycles are ignored entirely.
- Latency: pin change set up before sampling edge 0 → Pressed changes at edge DEBOUNCE_CYCLES+1.
- Pulses:
  - PressPulse and ReleasePulse are registered and asserted on the same edge that Pressed changes.
  - Each is high for exactly one cycle.
- Repeat FSM, per bit; counter sized for max(REPEAT_DELAY, REPEAT_PERIOD):
  - IDLE: Pressed rising → DELAY, cnt=0.
  - DELAY: cnt++. When cnt == REPEAT_DELAY-1 → RepeatPulse=1, go REPEAT, cnt=0.
  - REPEAT: cnt++. When cnt == REPEAT_PERIOD-1 → RepeatPulse=1, cnt=0.
  - Release (Pressed falling) in any state → IDLE, cnt=0. No RepeatPulse on that edge; release takes priority over a coincident repeat terminal count.
  - First RepeatPulse occurs REPEAT_DELAY edges after PressPulse; subsequent pulses every REPEAT_PERIOD edges.
  - REPEAT_DELAY == 0: FSM stays in IDLE and RepeatPulse is constantly 0.
- Independence:
  - Bits are fully independent; simultaneous events on different bits are all reported in the same cycle.
  - PressPulse and RepeatPulse are never high together on the same bit.
- Reset mid-operation:
  - Outputs clear immediately, without waiting for a clock edge.
  - After deassertion with a button still held, the press is re-detected as fresh: PressPulse at edge DEBOUNCE_CYCLES+1 counted from the first edge after deassertion.

Test Plan:
(Parameters: WIDTH=4, ACTIVE_LOW=1, DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3.)
1. Reset values: assert Reset with Buttons=4'hF, then release and run 20 cycles → all outputs remain 4'h0.
2. Clean press: Buttons=4'hE before edge 0 → Pressed[0]=1 and PressPulse[0]=1 at edge 5; PressPulse[0]=0 at edge 6; other bits stay 0.
3. Bounce rejection:
   - Bit 0 toggles 3 cycles low / 1 cycle high, repeated 5 times → Pressed, PressPulse and ReleasePulse all stay 0.
   - Then hold low → PressPulse[0] exactly 5 edges after the final fall.
4. Auto-repeat and release:
   - Hold bit 1 pressed → RepeatPulse[1] at 8, 11, 14 edges after PressPulse[1].
   - Release at PressPulse+15 → ReleasePulse[1] 5 edges later, with no further RepeatPulse after the release edge.
5. Simultaneous events:
   - Buttons=4'h0 in one step → PressPulse=4'hF in a single cycle.
   - Later, bit 2 is released on the same edge that bit 3's repeat fires → ReleasePulse=4'h4 and RepeatPulse=4'h8 in that cycle.
6. Reset mid-operation:
   - Assert Reset between edges while bit 0 is in REPEAT → all outputs read 0 before the next edge.
   - Deassert Reset with bit 0 still held → PressPulse[0] at edge 5 after deassertion, then first RepeatPulse[0] 8 edges after that.
